dbi_cfg_sequencer: RTL
======================

Name: dbi_cfg_sequencer

Overview:
Autonomous configuration master for dbi_tx_controller. Walks a programmable table of (register offset, data) pairs and issues each as a single-beat write on the controller's mc_* AW/W/B configuration channels, retrying on error responses. Sits between the system boot/control logic and the controller, so display init and the final control-register kick need no CPU.

Parameters:
ADDR_W, 32, configuration address width
MC_DATA_W, 8, configuration data width
MST_ID_W, 5, AXI ID width
TRANS_RESP_W, 2, B response width
IP_CONF_BASE_ADDR, 32'h3000_0000, base added to each entry offset
SEQ_ID, 5'h00, constant value driven on mc_awid_o
OFF_W, 8, entry offset width
SEQ_DEPTH, 16, table entries
SEQ_IDX_W, 4, log2(SEQ_DEPTH)
MAX_RETRY, 3, retries per entry after a non-OKAY bresp
TIMEOUT_CYC, 1024, B wait limit in cycles (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_i  in  1  run request, sampled in IDLE only
seq_len_i  in  SEQ_IDX_W+1  entries to issue (0..SEQ_DEPTH), latched on accepted start
tbl_wr_en_i  in  1  table write strobe, ignored while busy_o=1
tbl_wr_idx_i  in  SEQ_IDX_W  table entry index
tbl_wr_off_i  in  OFF_W  register offset
tbl_wr_data_i  in  MC_DATA_W  register data
mc_awid_o  out  MST_ID_W  = SEQ_ID
mc_awaddr_o  out  ADDR_W  IP_CONF_BASE_ADDR + zero-extended offset
mc_awvalid_o  out  1  AW valid
mc_awready_i  in  1  AW ready
mc_wdata_o  out  MC_DATA_W  entry data
mc_wvalid_o  out  1  W valid
mc_wready_i  in  1  W ready
mc_bresp_i  in  TRANS_RESP_W  write response
mc_bvalid_i  in  1  B valid
mc_bready_o  out  1  B ready
busy_o  out  1  high outside IDLE
done_o  out  1  one-cycle pulse at successful completion
err_o  out  1  sticky abort flag, cleared on next accepted start
err_idx_o  out  SEQ_IDX_W  entry index that aborted

Behaviour:
- Reset (rst=1 at posedge): state IDLE; all valids/bready, busy_o, done_o, err_o = 0; awaddr/awid/wdata/err_idx_o = 0; index and retry counters = 0; table contents unaffected. Reset mid-transaction drops valids immediately.
- Table: SEQ_DEPTH x (OFF_W+MC_DATA_W) registers, synchronous write, registered read.
- FSM states: IDLE, LOAD, ISSUE, RESP, DONE.
- IDLE: start_i=1 -> latch seq_len_i, idx=0, retry=0, clear err_o; seq_len_i=0 -> DONE, else LOAD.
- LOAD: fetch entry idx into awaddr/wdata registers -> ISSUE. Valids rise 2 cycles after start is sampled.
- ISSUE: awvalid and wvalid asserted together. Each drops the cycle after its own handshake; payload stable while valid. Both handshakes done (same or different cycles) -> RESP. No W before AW dependency.
- RESP: mc_bready_o=1. On bvalid & bready:
  - bresp=2'b00 -> idx+1; idx+1 == seq_len -> DONE, else LOAD.
  - bresp!=0 and retry<MAX_RETRY -> retry+1, reissue same entry via LOAD.
  - Otherwise -> err_o=1, err_idx_o=idx, IDLE (no done_o).
- Retry counter resets to 0 on every OKAY.
- DONE: done_o=1 for one cycle -> IDLE.
- busy_o=1 in LOAD, ISSUE, RESP, DONE.
- start_i outside IDLE is ignored; tbl_wr_en_i with busy_o=1 is ignored.
- seq_len_i > SEQ_DEPTH is clamped to SEQ_DEPTH.
- Next-entry valids rise 2 cycles after the B handshake.

Optional Feature:
DBI_CFG_SEQ_TIMEOUT_EN
- Defined: counter cleared on entry to RESP, increments each RESP cycle without bvalid. Reaching TIMEOUT_CYC -> err_o=1, err_idx_o=idx, IDLE; no retry.
- Undefined: no counter; RESP waits indefinitely; TIMEOUT_CYC unused.

Test Plan:
- Program 14 entries: offsets 1..D with data 01..0D, then offset 0 with data 01; seq_len=14; ready and bvalid always high -> 14 AW at 0x3000_0001..0x3000_000D then 0x3000_0000 with matching wdata, done_o once, err_o=0.
- Single entry (off 5, data A5); awready held low 3 cycles, wready high -> wvalid drops after 1 cycle, awvalid held 4 cycles with stable 0x3000_0005; exactly one B accepted.
- Entry 2 gets bresp=2'b10 once, then OKAY -> entry 2 issued twice, sequence completes, done_o=1, err_o=0.
- Entry 1 gets bresp=2'b10 on 4 consecutive attempts (MAX_RETRY=3) -> 4 issues, err_o=1, err_idx_o=1, no done_o, entry 2 never issued.
- seq_len=0 -> no valids, done_o pulse 2 cycles after start. rst asserted while awvalid=1 -> all outputs 0 next cycle, new start reruns from entry 0.
- With DBI_CFG_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, bvalid never asserted -> err_o=1 after 16 RESP cycles, err_idx_o=0.

Source files
------------

// File: rtl/dbi_cfg_sequencer.sv
// Table-driven configuration master: replays (offset, data) pairs as single-beat mc_* writes with retry.
// Optional B-response watchdog enabled by defining DBI_CFG_SEQ_TIMEOUT_EN.
module dbi_cfg_sequencer #(
  parameter int                          ADDR_W            = 32,
  parameter int                          MC_DATA_W         = 8,
  parameter int                          MST_ID_W          = 5,
  parameter int                          TRANS_RESP_W      = 2,
  parameter logic [ADDR_W-1:0]           IP_CONF_BASE_ADDR = 32'h3000_0000,
  parameter logic [MST_ID_W-1:0]         SEQ_ID            = 5'h00,
  parameter int                          OFF_W             = 8,
  parameter int                          SEQ_DEPTH         = 16,
  parameter int                          SEQ_IDX_W         = 4,
  parameter int                          MAX_RETRY         = 3,
  parameter int                          TIMEOUT_CYC       = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [SEQ_IDX_W:0]      seq_len_i,
  input  logic                    tbl_wr_en_i,
  input  logic [SEQ_IDX_W-1:0]    tbl_wr_idx_i,
  input  logic [OFF_W-1:0]        tbl_wr_off_i,
  input  logic [MC_DATA_W-1:0]    tbl_wr_data_i,
  output logic [MST_ID_W-1:0]     mc_awid_o,
  output logic [ADDR_W-1:0]       mc_awaddr_o,
  output logic                    mc_awvalid_o,
  input  logic                    mc_awready_i,
  output logic [MC_DATA_W-1:0]    mc_wdata_o,
  output logic                    mc_wvalid_o,
  input  logic                    mc_wready_i,
  input  logic [TRANS_RESP_W-1:0] mc_bresp_i,
  input  logic                    mc_bvalid_i,
  output logic                    mc_bready_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [SEQ_IDX_W-1:0]    err_idx_o
);

  localparam int LEN_W   = SEQ_IDX_W + 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [LEN_W-1:0]   DEPTH_LEN = LEN_W'(SEQ_DEPTH);
  localparam logic [LEN_W-1:0]   ONE_LEN   = LEN_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, RESP, DONE} state_t;

  state_t state_reg, state_next;

  logic [OFF_W-1:0]     tbl_off  [SEQ_DEPTH];
  logic [MC_DATA_W-1:0] tbl_data [SEQ_DEPTH];

  logic [LEN_W-1:0]     len_reg;
  logic [LEN_W-1:0]     idx_reg;
  logic [RETRY_W-1:0]   retry_reg;
  logic [ADDR_W-1:0]    awaddr_reg;
  logic [MC_DATA_W-1:0] wdata_reg;
  logic                 awvalid_reg, wvalid_reg;
  logic                 done_reg, err_reg;
  logic [SEQ_IDX_W-1:0] err_idx_reg;

  logic do_start, do_ok, do_retry, do_abort;
  logic [LEN_W-1:0] len_clamped;

  assign len_clamped = (seq_len_i > DEPTH_LEN) ? DEPTH_LEN : seq_len_i;

`ifdef DBI_CFG_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             tmo_hit;

  // Count only cycles spent in RESP with no response; leaving RESP rearms it.
  always_ff @(posedge clk) begin
    if (rst || state_reg != RESP) begin
      tmo_cnt_reg <= '0;
    end else if (!mc_bvalid_i) begin
      tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
    end
  end

  assign tmo_hit = (tmo_cnt_reg == TMO_LAST);
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    do_start   = 1'b0;
    do_ok      = 1'b0;
    do_retry   = 1'b0;
    do_abort   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          do_start   = 1'b1;
          state_next = (seq_len_i == '0) ? DONE : LOAD;
        end
      end
      LOAD: state_next = ISSUE;
      ISSUE: begin
        // A channel counts as finished once its valid has dropped or is handshaking now.
        if ((!awvalid_reg || mc_awready_i) && (!wvalid_reg || mc_wready_i)) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (mc_bvalid_i) begin
          if (mc_bresp_i == '0) begin
            do_ok      = 1'b1;
            state_next = ((idx_reg + ONE_LEN) == len_reg) ? DONE : LOAD;
          end else if (retry_reg < RETRY_MAX) begin
            do_retry   = 1'b1;
            state_next = LOAD;
          end else begin
            do_abort   = 1'b1;
            state_next = IDLE;
          end
        end else if (tmo_hit) begin
          do_abort   = 1'b1;
          state_next = IDLE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tbl_wr_en_i && state_reg == IDLE) begin
      tbl_off[tbl_wr_idx_i]  <= tbl_wr_off_i;
      tbl_data[tbl_wr_idx_i] <= tbl_wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg     <= '0;
      idx_reg     <= '0;
      retry_reg   <= '0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      err_idx_reg <= '0;
    end else begin
      done_reg <= (state_reg == DONE);
      if (do_start) begin
        len_reg   <= len_clamped;
        idx_reg   <= '0;
        retry_reg <= '0;
        err_reg   <= 1'b0;
      end
      if (state_reg == LOAD) begin
        awaddr_reg  <= IP_CONF_BASE_ADDR +
                       {{(ADDR_W-OFF_W){1'b0}}, tbl_off[idx_reg[SEQ_IDX_W-1:0]]};
        wdata_reg   <= tbl_data[idx_reg[SEQ_IDX_W-1:0]];
        awvalid_reg <= 1'b1;
        wvalid_reg  <= 1'b1;
      end
      if (awvalid_reg && mc_awready_i) awvalid_reg <= 1'b0;
      if (wvalid_reg && mc_wready_i)   wvalid_reg  <= 1'b0;
      if (do_ok) begin
        idx_reg   <= idx_reg + ONE_LEN;
        retry_reg <= '0;
      end
      if (do_retry) retry_reg <= retry_reg + RETRY_W'(1);
      if (do_abort) begin
        err_reg     <= 1'b1;
        err_idx_reg <= idx_reg[SEQ_IDX_W-1:0];
      end
    end
  end

  assign mc_awid_o    = SEQ_ID;
  assign mc_awaddr_o  = awaddr_reg;
  assign mc_awvalid_o = awvalid_reg;
  assign mc_wdata_o   = wdata_reg;
  assign mc_wvalid_o  = wvalid_reg;
  assign mc_bready_o  = (state_reg == RESP);
  assign busy_o       = (state_reg != IDLE);
  assign done_o       = done_reg;
  assign err_o        = err_reg;
  assign err_idx_o    = err_idx_reg;

endmodule
